// File: rtl/epl_ffram_bist_ctrl_pkg.sv
// Shared definitions for the FFRAM self-test sequencer: mode codes, FSM states,
// default latencies and the mode normalisation helper.
package epl_ffram_bist_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_PLAIN = 2'd0,
    MODE_RDIST = 2'd1,
    MODE_WFAIL = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CMD  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_CMD  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_CHK  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam int DEF_WR_LAT = 2;
  localparam int DEF_RD_LAT = 4;

  // Reserved mode code behaves exactly like plain mode.
  function automatic mode_e mode_norm(input logic [1:0] m);
    mode_e r;
    case (m)
      2'd1:    r = MODE_RDIST;
      2'd2:    r = MODE_WFAIL;
      default: r = MODE_PLAIN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/epl_ffram_bist_ctrl_checker.sv
// Readback classifier: selects the expectation for one read under the active mode
// and reports whether it passes and whether the RAM flagged an ECC error.
module epl_ffram_bist_ctrl_checker
  import epl_ffram_bist_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    WORD_WIDTH = 8,
  parameter logic [WORD_WIDTH-1:0] SEED       = 8'hA
) (
  input  logic [1:0]            mode,
  input  logic                  rd_hit,
  input  logic                  wf_hit,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] q,
  input  logic                  err,
  output logic                  pass,
  output logic                  err_seen
);

  logic [WORD_WIDTH-1:0] exp_s;
  logic                  unknown_s;

  // Unknown readback never passes and never increments the error count.
  always_comb begin
    exp_s     = WORD_WIDTH'(addr) + SEED;
    unknown_s = $isunknown({q, err});
    err_seen  = 1'b0;
    pass      = 1'b0;
    if (unknown_s) begin
      pass     = 1'b0;
      err_seen = 1'b0;
    end else if ((mode == MODE_RDIST) && rd_hit) begin
      pass     = (q == exp_s) && err;
      err_seen = err;
    end else if ((mode == MODE_WFAIL) && wf_hit) begin
      pass     = err;
      err_seen = err;
    end else begin
      pass     = (q == exp_s) && !err;
      err_seen = err;
    end
  end

endmodule

// File: rtl/epl_ffram_bist_ctrl.sv
// Write-all / read-all self-test sequencer driving the FFRAM command port and
// accumulating pass/fail statistics for the sweep.
module epl_ffram_bist_ctrl
  import epl_ffram_bist_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    WORD_WIDTH = 8,
  parameter logic [WORD_WIDTH-1:0] SEED       = 8'hA,
  parameter int                    WR_LAT     = DEF_WR_LAT,
  parameter int                    RD_LAT     = DEF_RD_LAT,
  localparam int                   WORD       = 2**ADDR_WIDTH
) (
  input  logic                  pCLOCK_i,
  input  logic                  pRESET_i,
  input  logic                  pSTART_i,
  input  logic [1:0]            pMODE_i,
  input  logic [WORD-1:0]       pRDMASK_i,
  input  logic [WORD-1:0]       pWFMASK_i,
  output logic [ADDR_WIDTH-1:0] pA_o,
  output logic [WORD_WIDTH-1:0] pD_o,
  output logic                  nWEN_o,
  output logic                  nCEN_o,
  output logic                  pFS_o,
  input  logic [WORD_WIDTH-1:0] pQ_i,
  input  logic                  pERR_i,
  output logic                  pBUSY_o,
  output logic                  pDONE_o,
  output logic                  pPASS_o,
  output logic [ADDR_WIDTH:0]   pFAILCNT_o,
  output logic [ADDR_WIDTH:0]   pERRCNT_o,
  output logic [ADDR_WIDTH-1:0] pFIRSTFAIL_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [7:0]            WR_LAST   = 8'(WR_LAT - 1);
  localparam logic [7:0]            RD_LAST   = 8'(RD_LAT - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};

  state_e                state_r;
  mode_e                 mode_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] addr_inc_s;
  logic [7:0]            lat_r;
  logic [WORD_WIDTH-1:0] q_r;
  logic                  e_r;
  logic                  chk_pass_s;
  logic                  chk_err_s;

  function automatic logic [WORD_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    return WORD_WIDTH'(a) + SEED;
  endfunction

  assign addr_inc_s = addr_r + ADDR_WIDTH'(1);

  epl_ffram_bist_ctrl_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .SEED       (SEED)
  ) u_checker (
    .mode     (mode_r),
    .rd_hit   (pRDMASK_i[addr_r]),
    .wf_hit   (pWFMASK_i[addr_r]),
    .addr     (addr_r),
    .q        (q_r),
    .err      (e_r),
    .pass     (chk_pass_s),
    .err_seen (chk_err_s)
  );

  // Sweep FSM; RAM commands are issued on the transition into a *_CMD state so
  // the registered command is valid exactly during that state.
  always_ff @(posedge pCLOCK_i) begin
    if (pRESET_i) begin
      state_r      <= ST_IDLE;
      mode_r       <= MODE_PLAIN;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      lat_r        <= 8'd0;
      q_r          <= {WORD_WIDTH{1'b0}};
      e_r          <= 1'b0;
      pA_o         <= {ADDR_WIDTH{1'b0}};
      pD_o         <= {WORD_WIDTH{1'b0}};
      nWEN_o       <= 1'b1;
      nCEN_o       <= 1'b1;
      pFS_o        <= 1'b0;
      pBUSY_o      <= 1'b0;
      pDONE_o      <= 1'b0;
      pPASS_o      <= 1'b0;
      pFAILCNT_o   <= CNT_ZERO;
      pERRCNT_o    <= CNT_ZERO;
      pFIRSTFAIL_o <= {ADDR_WIDTH{1'b0}};
    end else begin
      pA_o    <= {ADDR_WIDTH{1'b0}};
      pD_o    <= {WORD_WIDTH{1'b0}};
      nWEN_o  <= 1'b1;
      nCEN_o  <= 1'b1;
      pFS_o   <= 1'b0;
      pDONE_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pSTART_i) begin
            mode_r       <= mode_norm(pMODE_i);
            pFAILCNT_o   <= CNT_ZERO;
            pERRCNT_o    <= CNT_ZERO;
            pFIRSTFAIL_o <= {ADDR_WIDTH{1'b0}};
            pPASS_o      <= 1'b0;
            pBUSY_o      <= 1'b1;
            addr_r       <= {ADDR_WIDTH{1'b0}};
            pA_o         <= {ADDR_WIDTH{1'b0}};
            pD_o         <= pat({ADDR_WIDTH{1'b0}});
            nCEN_o       <= 1'b0;
            nWEN_o       <= 1'b0;
            pFS_o        <= (mode_norm(pMODE_i) == MODE_WFAIL);
            state_r      <= ST_WR_CMD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WR_CMD: begin
          lat_r   <= 8'd0;
          state_r <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (lat_r == WR_LAST) begin
            nCEN_o <= 1'b0;
            if (addr_r != ADDR_LAST) begin
              addr_r  <= addr_inc_s;
              pA_o    <= addr_inc_s;
              pD_o    <= pat(addr_inc_s);
              nWEN_o  <= 1'b0;
              pFS_o   <= (mode_r == MODE_WFAIL);
              state_r <= ST_WR_CMD;
            end else begin
              addr_r  <= {ADDR_WIDTH{1'b0}};
              pFS_o   <= (mode_r == MODE_RDIST);
              state_r <= ST_RD_CMD;
            end
          end else begin
            lat_r <= lat_r + 8'd1;
          end
        end
        ST_RD_CMD: begin
          lat_r   <= 8'd0;
          state_r <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (lat_r == RD_LAST) begin
            q_r     <= pQ_i;
            e_r     <= pERR_i;
            state_r <= ST_RD_CHK;
          end else begin
            lat_r <= lat_r + 8'd1;
          end
        end
        ST_RD_CHK: begin
          if (!chk_pass_s) begin
            pFAILCNT_o <= pFAILCNT_o + (ADDR_WIDTH+1)'(1);
            if (pFAILCNT_o == CNT_ZERO) begin
              pFIRSTFAIL_o <= addr_r;
            end
          end
          if (chk_err_s) begin
            pERRCNT_o <= pERRCNT_o + (ADDR_WIDTH+1)'(1);
          end
          if (addr_r != ADDR_LAST) begin
            addr_r  <= addr_inc_s;
            pA_o    <= addr_inc_s;
            nCEN_o  <= 1'b0;
            pFS_o   <= (mode_r == MODE_RDIST);
            state_r <= ST_RD_CMD;
          end else begin
            // Final read: fold this verdict into PASS so it is valid with DONE.
            pPASS_o <= (pFAILCNT_o == CNT_ZERO) && chk_pass_s;
            pDONE_o <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          pBUSY_o <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          pBUSY_o <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_epl_ffram_bist_ctrl.sv
// Self-checking bench: behavioural FFRAM with fault injection plus a per-address
// reference classification of each sweep.
module tb_epl_ffram_bist_ctrl;

  localparam int         AW     = 4;
  localparam int         WW     = 8;
  localparam int         NW     = 16;
  localparam int         WR     = 2;
  localparam int         RD     = 4;
  localparam logic [7:0] SEED   = 8'hA;
  localparam int         SWEEP  = NW * (3 + WR + RD) + 1;

  logic          clk = 1'b0;
  logic          pRESET_i, pSTART_i;
  logic [1:0]    pMODE_i;
  logic [NW-1:0] pRDMASK_i, pWFMASK_i;
  logic [AW-1:0] pA_o;
  logic [WW-1:0] pD_o;
  logic          nWEN_o, nCEN_o, pFS_o;
  logic [WW-1:0] pQ_i = 8'h00;
  logic          pERR_i = 1'b0;
  logic          pBUSY_o, pDONE_o, pPASS_o;
  logic [AW:0]   pFAILCNT_o, pERRCNT_o;
  logic [AW-1:0] pFIRSTFAIL_o;

  // RAM fault configuration, written only by the stimulus process
  logic [NW-1:0] flag_m = '0, corrupt_m = '0, stuck_m = '0;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  epl_ffram_bist_ctrl #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .SEED(SEED), .WR_LAT(WR), .RD_LAT(RD)) dut (
    .pCLOCK_i(clk), .pRESET_i(pRESET_i), .pSTART_i(pSTART_i), .pMODE_i(pMODE_i),
    .pRDMASK_i(pRDMASK_i), .pWFMASK_i(pWFMASK_i), .pA_o(pA_o), .pD_o(pD_o),
    .nWEN_o(nWEN_o), .nCEN_o(nCEN_o), .pFS_o(pFS_o), .pQ_i(pQ_i), .pERR_i(pERR_i),
    .pBUSY_o(pBUSY_o), .pDONE_o(pDONE_o), .pPASS_o(pPASS_o), .pFAILCNT_o(pFAILCNT_o),
    .pERRCNT_o(pERRCNT_o), .pFIRSTFAIL_o(pFIRSTFAIL_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural RAM and command monitor, evaluated mid-cycle
  logic [WW-1:0] mem [NW];
  logic [NW-1:0] bad_bits = '0;
  logic [WW-1:0] pend_q = 8'h00;
  logic          pend_e = 1'b0;
  int rd_cnt = 0, wr_exp = 0, rd_exp = 0, n_wr = 0, n_rd = 0;
  int n_fs_wr = 0, n_fs_rd = 0, seq_err = 0, n_done = 0;
  logic prev_cmd = 1'b0;

  always @(negedge clk) begin
    logic valid;
    valid = 1'b0;
    if (pRESET_i || (pSTART_i && !pBUSY_o)) begin
      wr_exp = 0; rd_exp = 0; n_wr = 0; n_rd = 0; n_fs_wr = 0; n_fs_rd = 0;
      seq_err = 0; n_done = 0; prev_cmd = 1'b0;
    end else begin
      if (pDONE_o) n_done++;
      if (!nCEN_o) begin
        if (prev_cmd) seq_err++;
        if (!nWEN_o) begin
          if (int'(pA_o) != wr_exp || pD_o != 8'(wr_exp + int'(SEED))) seq_err++;
          wr_exp++; n_wr++;
          if (pFS_o) n_fs_wr++;
          mem[pA_o] = pD_o ^ ((corrupt_m[pA_o] && pFS_o) ? 8'hFF : 8'h00);
          bad_bits[pA_o] = corrupt_m[pA_o] && pFS_o;
        end else begin
          if (int'(pA_o) != rd_exp || n_wr != NW) seq_err++;
          rd_exp++; n_rd++;
          if (pFS_o) n_fs_rd++;
          pend_q = mem[pA_o] ^ {7'd0, stuck_m[pA_o]};
          pend_e = bad_bits[pA_o] || (flag_m[pA_o] && pFS_o);
          rd_cnt = RD;
        end
      end else if (pA_o != 4'd0 || pD_o != 8'd0 || !nWEN_o || pFS_o) begin
        seq_err++;
      end
      prev_cmd = !nCEN_o;
    end
    if (!(!nCEN_o && nWEN_o) && rd_cnt > 0) begin
      rd_cnt--;
      valid = (rd_cnt == 0);
    end
    pQ_i   = valid ? pend_q : (pend_q ^ 8'h5A);
    pERR_i = valid ? pend_e : !pend_e;
  end

  // Reference: per-address classification straight from the mode rules
  task automatic model(input int mode, input logic [NW-1:0] rdm, input logic [NW-1:0] wfm,
                       output int fails, output int errs, output int first);
    int m;
    m = (mode == 3) ? 0 : mode;
    fails = 0; errs = 0; first = 0;
    for (int a = 0; a < NW; a++) begin
      logic [7:0] d, q;
      logic e, bad, ok;
      d   = 8'((a + int'(SEED)) % 256);
      bad = (m == 2) && corrupt_m[a];
      q   = (bad ? ~d : d) ^ {7'd0, stuck_m[a]};
      e   = bad || ((m == 1) && flag_m[a]);
      if (m == 1 && rdm[a])      ok = (q == d) && e;
      else if (m == 2 && wfm[a]) ok = e;
      else                       ok = (q == d) && !e;
      if (!ok) begin
        if (fails == 0) first = a;
        fails++;
      end
      if (e) errs++;
    end
  endtask

  task automatic run_sweep(input string tag, input int mode, input logic [NW-1:0] rdm,
                           input logic [NW-1:0] wfm, input logic [NW-1:0] flg,
                           input logic [NW-1:0] cor, input logic [NW-1:0] stk, input bit repulse);
    int ef, ee, efirst, n, m;
    flag_m = flg; corrupt_m = cor; stuck_m = stk;
    pMODE_i = 2'(mode); pRDMASK_i = rdm; pWFMASK_i = wfm;
    model(mode, rdm, wfm, ef, ee, efirst);
    m = (mode == 3) ? 0 : mode;
    pSTART_i = 1'b1;
    @(negedge clk);
    pSTART_i = 1'b0;
    n = 1;
    check_eq({tag, "_busy"}, 32'(pBUSY_o), 32'd1);
    while (!pDONE_o && n < 400) begin
      @(negedge clk);
      n++;
      pSTART_i = repulse && (n == 40 || n == 90);
    end
    pSTART_i = 1'b0;
    check_eq({tag, "_cycles"}, n, SWEEP);
    check_eq({tag, "_failcnt"}, 32'(pFAILCNT_o), ef);
    check_eq({tag, "_errcnt"}, 32'(pERRCNT_o), ee);
    check_eq({tag, "_firstfail"}, 32'(pFIRSTFAIL_o), efirst);
    check_eq({tag, "_pass"}, 32'(pPASS_o), (ef == 0) ? 32'd1 : 32'd0);
    @(negedge clk);
    check_eq({tag, "_done_drop"}, {pDONE_o, pBUSY_o}, 32'd0);
    check_eq({tag, "_pass_hold"}, 32'(pPASS_o), (ef == 0) ? 32'd1 : 32'd0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_ndone"}, n_done, 32'd1);
    check_eq({tag, "_cmds"}, (n_wr << 8) | n_rd, (NW << 8) | NW);
    check_eq({tag, "_fs_wr"}, n_fs_wr, (m == 2) ? NW : 0);
    check_eq({tag, "_fs_rd"}, n_fs_rd, (m == 1) ? NW : 0);
    check_eq({tag, "_seq"}, seq_err, 32'd0);
  endtask

  initial begin
    int n;
    pRESET_i = 1'b1; pSTART_i = 1'b0; pMODE_i = 2'd0; pRDMASK_i = '0; pWFMASK_i = '0;
    repeat (3) @(negedge clk);
    pSTART_i = 1'b1;
    @(negedge clk);
    pRESET_i = 1'b0; pSTART_i = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd", {nCEN_o, nWEN_o, pFS_o}, 32'b110);
    check_eq("rst_bus", {pA_o, pD_o}, 32'd0);
    check_eq("rst_stat", {pBUSY_o, pDONE_o, pPASS_o}, 32'd0);
    check_eq("rst_cnt", {pFAILCNT_o, pERRCNT_o, pFIRSTFAIL_o}, 32'd0);

    run_sweep("plain", 0, '0, '0, '0, '0, '0, 1'b0);
    run_sweep("rdist", 1, 16'h000C, '0, 16'h000C, '0, '0, 1'b0);
    run_sweep("wfail", 2, '0, 16'h0030, '0, 16'h0030, '0, 1'b0);
    run_sweep("wfail_nomask", 2, '0, '0, '0, 16'h0030, '0, 1'b0);
    run_sweep("stuck", 0, '0, '0, '0, '0, 16'h0080, 1'b0);
    run_sweep("repulse", 0, '0, '0, '0, '0, 16'h0100, 1'b1);
    run_sweep("rsvd", 3, 16'hFFFF, 16'hFFFF, 16'h00F0, 16'h0F00, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_sweep($sformatf("rnd%0d", i), int'($urandom_range(0, 3)), 16'($urandom()),
                16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom() & 32'h0000_0F0F),
                1'b0);
    end

    // Abort during the read wait of address 5
    flag_m = '0; corrupt_m = '0; stuck_m = '0; pMODE_i = 2'd0;
    pSTART_i = 1'b1;
    @(negedge clk);
    pSTART_i = 1'b0;
    n = 0;
    while (!(!nCEN_o && nWEN_o && pA_o == 4'd5) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort_reached", 32'(n < 400), 32'd1);
    @(negedge clk);
    pRESET_i = 1'b1;
    @(negedge clk);
    pRESET_i = 1'b0;
    check_eq("abort_cmd", {nCEN_o, pBUSY_o, pDONE_o}, 32'b100);
    check_eq("abort_cnt", {pFAILCNT_o, pERRCNT_o}, 32'd0);
    repeat (200) @(negedge clk);
    check_eq("abort_nodone", n_done, 32'd0);
    run_sweep("restart", 0, '0, '0, '0, '0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
